// File: rtl/gtxe2_oob_pkg.sv
// Shared state encoding and parameter defaults for the GTXE2 SATA host OOB sequencer.
package gtxe2_oob_pkg;

  localparam int unsigned OOB_TIMEOUT_DEF     = 4096;
  localparam int unsigned OOB_TMR_W_DEF       = 16;
  localparam int unsigned OOB_MAX_RETRIES_DEF = 3;
  localparam int unsigned OOB_STATE_W         = 4;

  typedef enum logic [OOB_STATE_W-1:0] {
    ST_IDLE          = 4'd0,
    ST_SEND_INIT     = 4'd1,
    ST_WAIT_INIT_FIN = 4'd2,
    ST_WAIT_DEV_INIT = 4'd3,
    ST_SEND_WAKE     = 4'd4,
    ST_WAIT_WAKE_FIN = 4'd5,
    ST_WAIT_DEV_WAKE = 4'd6,
    ST_WAIT_ALIGN    = 4'd7,
    ST_LINK_UP       = 4'd8,
    ST_FAIL          = 4'd9
  } oob_state_e;

  // Only the WAIT_* states are guarded by the phase timer.
  function automatic logic is_wait_state(input oob_state_e s);
    return s inside {ST_WAIT_INIT_FIN, ST_WAIT_DEV_INIT, ST_WAIT_WAKE_FIN,
                     ST_WAIT_DEV_WAKE, ST_WAIT_ALIGN};
  endfunction

endpackage

// File: rtl/gtxe2_oob_timer.sv
// Phase timer: synchronous clear, count enable, saturating count, and a flag
// raised on the last permitted cycle of a phase (count == TIMEOUT_CYCLES-1).
module gtxe2_oob_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMR_W          = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  // NOTE: state held across clock edges is assigned with <= so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TMR_MAX)) begin
      count <= count + TMR_W'(1);
    end
  end

  assign timeout = en && (count == TMR_LAST);

endmodule

// File: rtl/gtxe2_chnl_oob_ctrl.sv
// Host-side SATA OOB sequencer for the GTXE2 TX OOB burst generator.
// Define OOB_CTRL_RETRY_EN to retry COMINIT up to MAX_RETRIES times after a phase timeout.
module gtxe2_chnl_oob_ctrl
  import gtxe2_oob_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = OOB_TIMEOUT_DEF,
  parameter int unsigned TMR_W          = OOB_TMR_W_DEF,
  parameter int unsigned MAX_RETRIES    = OOB_MAX_RETRIES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       txcominit,
  output logic       txcomwake,
  input  logic       txcomfinish,
  input  logic       rxcominitdet,
  input  logic       rxcomwakedet,
  input  logic       rxaligndet,
  output logic       link_up,
  output logic       busy,
  output logic       fail,
  output logic [1:0] retry_cnt
);

`ifdef OOB_CTRL_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  // A zero limit makes every timeout terminal and leaves the retry counter at 0.
  localparam logic [1:0] RETRY_LIMIT = RETRY_EN ? 2'(MAX_RETRIES) : 2'd0;

  oob_state_e state_q, state_d;
  logic [1:0] retry_q, retry_d;
  logic       tmr_clr, tmr_en, tmr_timeout;
  logic       timeout_hit;

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = is_wait_state(state_q);

  gtxe2_oob_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .timeout (tmr_timeout)
  );

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_d = ST_SEND_INIT;
          retry_d = '0;
        end
      end
      ST_SEND_INIT: state_d = ST_WAIT_INIT_FIN;
      ST_WAIT_INIT_FIN: begin
        if (txcomfinish) state_d = ST_WAIT_DEV_INIT;
        else             timeout_hit = tmr_timeout;
      end
      ST_WAIT_DEV_INIT: begin
        if (rxcominitdet) state_d = ST_SEND_WAKE;
        else              timeout_hit = tmr_timeout;
      end
      ST_SEND_WAKE: state_d = ST_WAIT_WAKE_FIN;
      ST_WAIT_WAKE_FIN: begin
        if (txcomfinish) state_d = ST_WAIT_DEV_WAKE;
        else             timeout_hit = tmr_timeout;
      end
      ST_WAIT_DEV_WAKE: begin
        if (rxcomwakedet) state_d = ST_WAIT_ALIGN;
        else              timeout_hit = tmr_timeout;
      end
      ST_WAIT_ALIGN: begin
        if (rxaligndet) state_d = ST_LINK_UP;
        else            timeout_hit = tmr_timeout;
      end
      ST_LINK_UP: begin
        // Device-initiated COMINIT means the device reset; restart from scratch.
        if (rxcominitdet) begin
          state_d = ST_SEND_INIT;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      if (retry_q != RETRY_LIMIT) begin
        state_d = ST_SEND_INIT;
        retry_d = retry_q + 2'd1;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      txcominit <= 1'b0;
      txcomwake <= 1'b0;
      link_up   <= 1'b0;
      busy      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      txcominit <= (state_d == ST_SEND_INIT);
      txcomwake <= (state_d == ST_SEND_WAKE);
      link_up   <= (state_d == ST_LINK_UP);
      busy      <= !(state_d inside {ST_IDLE, ST_LINK_UP, ST_FAIL});
      fail      <= (state_d == ST_FAIL);
    end
  end

  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_gtxe2_chnl_oob_ctrl.sv
// Scoreboard bench for gtxe2_chnl_oob_ctrl: stimulus queues expected output events
// (pulse/edge, cycle, retry_cnt); a negedge monitor pops and compares them.
module tb_gtxe2_chnl_oob_ctrl;

  localparam int TO = 64;
`ifdef OOB_CTRL_RETRY_EN
  localparam int NRET = 3;
`else
  localparam int NRET = 0;
`endif

  typedef enum int {EV_INIT, EV_WAKE, EV_UP, EV_FAIL} ev_kind_e;
  typedef enum int {IN_START, IN_FIN, IN_INITDET, IN_WAKEDET, IN_ALIGN} in_e;
  typedef struct {
    ev_kind_e kind;
    int       c;
    int       r;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, txcomfinish, rxcominitdet, rxcomwakedet, rxaligndet;
  logic       txcominit, txcomwake, link_up, busy, fail;
  logic [1:0] retry_cnt;

  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];
  logic prev_up   = 1'b0;
  logic prev_fail = 1'b0;

  gtxe2_chnl_oob_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .TMR_W          (16),
    .MAX_RETRIES    (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .txcominit    (txcominit),
    .txcomwake    (txcomwake),
    .txcomfinish  (txcomfinish),
    .rxcominitdet (rxcominitdet),
    .rxcomwakedet (rxcomwakedet),
    .rxaligndet   (rxaligndet),
    .link_up      (link_up),
    .busy         (busy),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic mon_event(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", k, e.kind);
      check({"ev_cycle_", e.kind.name()}, cyc, e.c);
      check({"ev_retry_", e.kind.name()}, {30'b0, retry_cnt}, e.r);
    end
  endtask

  // Monitor: samples on the falling edge, half a cycle away from DUT updates.
  always @(negedge clk) begin
    if (txcominit || txcomwake) check("tx_exclusive", {31'b0, txcominit & txcomwake}, 0);
    if (txcominit) mon_event(EV_INIT);
    if (txcomwake) mon_event(EV_WAKE);
    if (link_up && !prev_up) mon_event(EV_UP);
    if (fail && !prev_fail) mon_event(EV_FAIL);
    prev_up   <= link_up;
    prev_fail <= fail;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_ev(input ev_kind_e k, input int c, input int r);
    ev_t e;
    e.kind = k;
    e.c    = c;
    e.r    = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) check("stim_schedule", cyc, c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_in(input in_e s, input logic v);
    case (s)
      IN_START:   start        = v;
      IN_FIN:     txcomfinish  = v;
      IN_INITDET: rxcominitdet = v;
      IN_WAKEDET: rxcomwakedet = v;
      IN_ALIGN:   rxaligndet   = v;
      default:    ;
    endcase
  endtask

  task automatic pulse_at(input int c, input in_e s);
    wait_cyc(c);
    set_in(s, 1'b1);
    @(negedge clk);
    set_in(s, 1'b0);
  endtask

  task automatic start_at(input int c, output int p);
    p = c + 1;
    expect_ev(EV_INIT, p, 0);
    pulse_at(c, IN_START);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_txcominit"}, {31'b0, txcominit}, 0);
    check({tag, "_txcomwake"}, {31'b0, txcomwake}, 0);
    check({tag, "_link_up"},   {31'b0, link_up},   0);
    check({tag, "_busy"},      {31'b0, busy},      0);
    check({tag, "_fail"},      {31'b0, fail},      0);
    check({tag, "_retry_cnt"}, {30'b0, retry_cnt}, 0);
  endtask

  // Drives the rest of a bring-up after a txcominit pulse seen at cycle p.
  task automatic complete_from_init(input int p, input bit boundary);
    int fin1, idet, w, fin2, wdet, adet;
    fin1 = p + 10;
    pulse_at(fin1, IN_FIN);
    idet = boundary ? (fin1 + 1) + TO - 1 : fin1 + 5;
    w    = idet + 1;
    expect_ev(EV_WAKE, w, 0);
    pulse_at(idet, IN_INITDET);
    fin2 = w + 10;
    pulse_at(fin2, IN_FIN);
    wdet = fin2 + 5;
    pulse_at(wdet, IN_WAKEDET);
    adet = wdet + 5;
    expect_ev(EV_UP, adet + 1, 0);
    pulse_at(adet, IN_ALIGN);
    wait_cyc(adet + 3);
    check("up_link_up",   {31'b0, link_up},   1);
    check("up_fail",      {31'b0, fail},      0);
    check("up_busy",      {31'b0, busy},      0);
    check("up_retry_cnt", {30'b0, retry_cnt}, 0);
  endtask

  initial begin
    int p, d;
    reset_n      = 1'b0;
    start        = 1'b0;
    txcomfinish  = 1'b0;
    rxcominitdet = 1'b0;
    rxcomwakedet = 1'b0;
    rxaligndet   = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Happy path from IDLE.
    start_at(cyc, p);
    complete_from_init(p, 1'b0);

    // start is ignored while the link is up.
    d = cyc;
    pulse_at(d, IN_START);
    wait_cyc(d + 5);
    check("start_in_up_link_up", {31'b0, link_up}, 1);

    // Device reset from LINK_UP restarts the whole sequence.
    d = cyc;
    expect_ev(EV_INIT, d + 1, 0);
    pulse_at(d, IN_INITDET);
    check("devrst_link_up", {31'b0, link_up}, 0);
    check("devrst_busy",    {31'b0, busy},    1);
    complete_from_init(d + 1, 1'b0);

    // Boundary: device COMINIT on the last permitted cycle wins over timeout.
    d = cyc;
    expect_ev(EV_INIT, d + 1, 0);
    pulse_at(d, IN_INITDET);
    complete_from_init(d + 1, 1'b1);

    // Async reset while waiting for device COMWAKE.
    d = cyc;
    expect_ev(EV_INIT, d + 1, 0);
    pulse_at(d, IN_INITDET);
    p = d + 1;
    pulse_at(p + 10, IN_FIN);
    expect_ev(EV_WAKE, p + 17, 0);
    pulse_at(p + 16, IN_INITDET);
    pulse_at(p + 27, IN_FIN);
    wait_cyc(p + 31);
    check("pre_reset_busy", {31'b0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Fresh start plus spurious events and start toggling while busy.
    start_at(cyc, p);
    pulse_at(p + 2, IN_WAKEDET);
    pulse_at(p + 4, IN_ALIGN);
    check("spurious_busy", {31'b0, busy}, 1);
    pulse_at(p + 5, IN_START);
    pulse_at(p + 6, IN_START);
    complete_from_init(p, 1'b0);

    // No device: COMINIT never answered, timeouts (and retries if enabled) end in FAIL.
    d = cyc;
    expect_ev(EV_INIT, d + 1, 0);
    pulse_at(d, IN_INITDET);
    p = d + 1;
    for (int i = 0; i <= NRET; i++) begin
      pulse_at(p + 10, IN_FIN);
      if (i < NRET) expect_ev(EV_INIT, p + TO + 11, i + 1);
      else          expect_ev(EV_FAIL, p + TO + 11, NRET);
      p = p + TO + 11;
    end
    wait_cyc(p + 5);
    check("nodev_fail",      {31'b0, fail},      1);
    check("nodev_busy",      {31'b0, busy},      0);
    check("nodev_link_up",   {31'b0, link_up},   0);
    check("nodev_retry_cnt", {30'b0, retry_cnt}, NRET);

    // Restart from FAIL clears the retry count.
    start_at(cyc, p);
    complete_from_init(p, 1'b0);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
